// File: rtl/nvram_upload_server.sv
// -----------------------------------------------------------------------------
// nvram_upload_server
//
// Serves HPS upload (save) requests out of the core's NVRAM. Each ioctl_rd
// strobe for an in-range address becomes one arbitrated NVRAM read, and the
// HPS is held off with ioctl_wait until the byte is in ioctl_din.
// Out-of-range strobes are answered at once with 8'hFF.
//
// Optional feature macro: NVRAM_UPLOAD_CKSUM_EN
//   When defined, a read of address exactly 2^ADDR_W returns the 8-bit two's
//   complement of the sum of every byte served in the current session. The
//   accumulator is only built when the macro is defined.
//
// Parameters
//   ADDR_W        NVRAM address width (depth = 2^ADDR_W bytes)
//   INDEX         ioctl_index value that selects this block
//
// Ports
//   clk_sys       system clock, rising edge
//   reset_n       asynchronous active-low reset
//   ioctl_upload  HPS upload session active (level)
//   ioctl_index   session target index
//   ioctl_rd      one-cycle strobe: byte at ioctl_addr requested
//   ioctl_addr    requested byte address
//   ioctl_din     returned byte (registered)
//   ioctl_wait    HPS stall while a fetch is outstanding (combinational)
//   ram_addr      NVRAM read address (registered)
//   ram_rd        NVRAM read request, held until granted (registered)
//   ram_gnt       core grants the NVRAM port this cycle
//   ram_q         NVRAM data, valid the cycle after a granted ram_rd
//   busy          session active for this index (registered)
//   done          one-cycle pulse when a session ends (registered)
// -----------------------------------------------------------------------------
module nvram_upload_server #(
   parameter int unsigned ADDR_W = 10,
   parameter logic [7:0]  INDEX  = 8'd4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic              ram_gnt,
   input  logic [7:0]        ram_q,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_REQ,
      S_DATA
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        din_q, din_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              sel;
   logic              in_range;
   logic [7:0]        oor_byte;

`ifdef NVRAM_UPLOAD_CKSUM_EN
   localparam logic [24:0] CKSUM_ADDR = 25'(1) << ADDR_W;
   logic [7:0]        acc_q, acc_d;
`endif

   assign sel      = ioctl_upload && (ioctl_index == INDEX);
   // Any set bit above the NVRAM address width means out of range; no wrap.
   assign in_range = (ioctl_addr[24:ADDR_W] == '0);

`ifdef NVRAM_UPLOAD_CKSUM_EN
   assign oor_byte = (ioctl_addr == CKSUM_ADDR) ? (~acc_q + 8'd1) : 8'hFF;
`else
   assign oor_byte = 8'hFF;
`endif

   always_comb begin
      state_d = state_q;
      din_d   = din_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef NVRAM_UPLOAD_CKSUM_EN
      acc_d   = acc_q;
`endif
      if (state_q != S_IDLE && !sel) begin
         // Session abort from any active state; ioctl_din keeps its value.
         state_d = S_IDLE;
         rd_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sel) begin
                  state_d = S_ARMED;
                  busy_d  = 1'b1;
`ifdef NVRAM_UPLOAD_CKSUM_EN
                  acc_d   = '0;
`endif
               end
            end
            S_ARMED: begin
               if (ioctl_rd) begin
                  if (in_range) begin
                     addr_d  = ioctl_addr[ADDR_W-1:0];
                     rd_d    = 1'b1;
                     state_d = S_REQ;
                  end else begin
                     din_d   = oor_byte;
                  end
               end
            end
            S_REQ: begin
               // Strobes here and in DATA are protocol violations: ignored.
               if (ram_gnt) begin
                  rd_d    = 1'b0;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               din_d   = ram_q;
`ifdef NVRAM_UPLOAD_CKSUM_EN
               acc_d   = acc_q + ram_q;
`endif
               state_d = S_ARMED;
            end
            default: begin
               state_d = S_IDLE;
               rd_d    = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         din_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef NVRAM_UPLOAD_CKSUM_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef NVRAM_UPLOAD_CKSUM_EN
         acc_q   <= acc_d;
`endif
      end
   end

   // Stall raised combinationally in the strobe cycle so the HPS never
   // samples a stale byte; out-of-range strobes complete without a stall.
   assign ioctl_wait = (state_q == S_REQ) || (state_q == S_DATA) ||
                       ((state_q == S_ARMED) && ioctl_rd && in_range);

   assign ioctl_din = din_q;
   assign ram_addr  = addr_q;
   assign ram_rd    = rd_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_nvram_upload_server.sv
module tb_nvram_upload_server;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [9:0]  ram_addr;
   logic        ram_rd;
   logic        ram_gnt;
   logic [7:0]  ram_q;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:1023];

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk_sys = ~clk_sys;

   nvram_upload_server #(
      .ADDR_W(10),
      .INDEX (8'd4)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ioctl_upload(ioctl_upload),
      .ioctl_index (ioctl_index),
      .ioctl_rd    (ioctl_rd),
      .ioctl_addr  (ioctl_addr),
      .ioctl_din   (ioctl_din),
      .ioctl_wait  (ioctl_wait),
      .ram_addr    (ram_addr),
      .ram_rd      (ram_rd),
      .ram_gnt     (ram_gnt),
      .ram_q       (ram_q),
      .busy        (busy),
      .done        (done)
   );

   // Synchronous NVRAM read port: data the cycle after a granted request.
   always @(posedge clk_sys) begin
      if (ram_rd && ram_gnt) ram_q <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
      ioctl_rd = 1'b0; ioctl_addr = '0; ram_gnt = 1'b1; ram_q = 8'h00;
      #3;
      total_cnt++;
      if ({ioctl_din, ioctl_wait, ram_addr, ram_rd, busy, done} !== 22'd0)
         $display("FAIL reset_outputs din=%h wait=%b addr=%h rd=%b busy=%b done=%b expected all 0",
                  ioctl_din, ioctl_wait, ram_addr, ram_rd, busy, done);
      else pass_cnt++;
      tick();
      reset_n = 1'b1;
      ioctl_upload = 1'b1; ioctl_index = 8'd4;
      tick();
      total_cnt++;
      if (busy !== 1'b1 || ioctl_wait !== 1'b0)
         $display("FAIL session_start busy=%b wait=%b expected busy=1 wait=0", busy, ioctl_wait);
      else pass_cnt++;
   endtask

   task automatic test_basic_read();
      mem[5] = 8'h3C; ram_gnt = 1'b1;
      ioctl_rd = 1'b1; ioctl_addr = 25'd5;
      #1;
      total_cnt++;
      if (ioctl_wait !== 1'b1) $display("FAIL basic_T_wait got=%b expected=1", ioctl_wait);
      else pass_cnt++;
      tick(); ioctl_rd = 1'b0;
      total_cnt++;
      if (ram_rd !== 1'b1 || ram_addr !== 10'd5 || ioctl_wait !== 1'b1)
         $display("FAIL basic_T1 rd=%b addr=%0d wait=%b expected rd=1 addr=5 wait=1",
                  ram_rd, ram_addr, ioctl_wait);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ram_rd !== 1'b0 || ioctl_wait !== 1'b1)
         $display("FAIL basic_T2 rd=%b wait=%b expected rd=0 wait=1", ram_rd, ioctl_wait);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ioctl_din !== 8'h3C || ioctl_wait !== 1'b0)
         $display("FAIL basic_T3 din=%h wait=%b expected din=3c wait=0", ioctl_din, ioctl_wait);
      else pass_cnt++;
   endtask

   task automatic test_gnt_stall();
      mem[9] = 8'hA5; mem[3] = 8'h77; ram_gnt = 1'b0;
      ioctl_rd = 1'b1; ioctl_addr = 25'd9;
      tick(); ioctl_rd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (ram_rd !== 1'b1 || ioctl_wait !== 1'b1 || ram_addr !== 10'd9)
            $display("FAIL stall_cycle%0d rd=%b wait=%b addr=%0d expected rd=1 wait=1 addr=9",
                     i, ram_rd, ioctl_wait, ram_addr);
         else pass_cnt++;
         // Illegal strobe while a fetch is pending must not re-latch.
         if (i == 1) begin ioctl_rd = 1'b1; ioctl_addr = 25'd3; end
         else ioctl_rd = 1'b0;
         tick();
      end
      ioctl_rd = 1'b0;
      ram_gnt = 1'b1;
      total_cnt++;
      if (ram_rd !== 1'b1 || ram_addr !== 10'd9)
         $display("FAIL stall_T5 rd=%b addr=%0d expected rd=1 addr=9", ram_rd, ram_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ioctl_wait !== 1'b1 || ioctl_din !== 8'h3C)
         $display("FAIL stall_T6 wait=%b din=%h expected wait=1 din=3c", ioctl_wait, ioctl_din);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ioctl_din !== 8'hA5 || ioctl_wait !== 1'b0)
         $display("FAIL stall_T7 din=%h wait=%b expected din=a5 wait=0", ioctl_din, ioctl_wait);
      else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      ioctl_rd = 1'b1; ioctl_addr = 25'h1000000;
      #1;
      total_cnt++;
      if (ioctl_wait !== 1'b0) $display("FAIL oor_top_wait got=%b expected=0", ioctl_wait);
      else pass_cnt++;
      tick(); ioctl_rd = 1'b0;
      total_cnt++;
      if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0 || ram_rd !== 1'b0)
         $display("FAIL oor_top din=%h wait=%b rd=%b expected din=ff wait=0 rd=0",
                  ioctl_din, ioctl_wait, ram_rd);
      else pass_cnt++;
      // Read a known byte, then an address just above the checksum slot.
      ioctl_rd = 1'b1; ioctl_addr = 25'd5;
      tick(); ioctl_rd = 1'b0; tick(); tick();
      ioctl_rd = 1'b1; ioctl_addr = 25'd1025;
      #1;
      total_cnt++;
      if (ioctl_wait !== 1'b0 || ioctl_din !== 8'h3C)
         $display("FAIL oor_1025_T wait=%b din=%h expected wait=0 din=3c", ioctl_wait, ioctl_din);
      else pass_cnt++;
      tick(); ioctl_rd = 1'b0;
      total_cnt++;
      if (ioctl_din !== 8'hFF) $display("FAIL oor_1025 din=%h expected=ff", ioctl_din);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      ram_gnt = 1'b0;
      ioctl_rd = 1'b1; ioctl_addr = 25'd5;
      tick(); ioctl_rd = 1'b0;
      total_cnt++;
      if (ram_rd !== 1'b1) $display("FAIL abort_in_req rd=%b expected=1", ram_rd);
      else pass_cnt++;
      ioctl_upload = 1'b0;
      tick();
      total_cnt++;
      if (ram_rd !== 1'b0 || ioctl_wait !== 1'b0 || busy !== 1'b0 || done !== 1'b1 ||
          ioctl_din !== 8'hFF)
         $display("FAIL abort_next rd=%b wait=%b busy=%b done=%b din=%h expected rd=0 wait=0 busy=0 done=1 din=ff",
                  ram_rd, ioctl_wait, busy, done, ioctl_din);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL abort_done_width done=%b expected=0", done);
      else pass_cnt++;
      ram_gnt = 1'b1;
   endtask

   task automatic test_unselected();
      ioctl_upload = 1'b1; ioctl_index = 8'd0;
      for (int i = 0; i < 3; i++) begin
         ioctl_rd = 1'b1; ioctl_addr = 25'(i + 5);
         #1;
         total_cnt++;
         if (ioctl_wait !== 1'b0) $display("FAIL unsel_wait%0d got=%b expected=0", i, ioctl_wait);
         else pass_cnt++;
         tick(); ioctl_rd = 1'b0;
         total_cnt++;
         if (ram_rd !== 1'b0 || busy !== 1'b0 || ioctl_din !== 8'hFF || done !== 1'b0)
            $display("FAIL unsel_%0d rd=%b busy=%b din=%h done=%b expected rd=0 busy=0 din=ff done=0",
                     i, ram_rd, busy, ioctl_din, done);
         else pass_cnt++;
      end
   endtask

   task automatic test_checksum();
      logic [7:0] exp_ck;
`ifdef NVRAM_UPLOAD_CKSUM_EN
      exp_ck = 8'hF6;
`else
      exp_ck = 8'hFF;
`endif
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
      ioctl_index = 8'd4;
      tick();
      for (int a = 0; a < 4; a++) begin
         ioctl_rd = 1'b1; ioctl_addr = 25'(a);
         tick(); ioctl_rd = 1'b0; tick(); tick();
         total_cnt++;
         if (ioctl_din !== 8'(a + 1) || ioctl_wait !== 1'b0)
            $display("FAIL ck_byte%0d din=%h wait=%b expected din=%h wait=0",
                     a, ioctl_din, ioctl_wait, 8'(a + 1));
         else pass_cnt++;
      end
      ioctl_rd = 1'b1; ioctl_addr = 25'd1024;
      tick(); ioctl_rd = 1'b0;
      total_cnt++;
      if (ioctl_din !== exp_ck) $display("FAIL ck_sum din=%h expected=%h", ioctl_din, exp_ck);
      else pass_cnt++;
      ioctl_rd = 1'b1; ioctl_addr = 25'h1000000;
      tick(); ioctl_rd = 1'b0;
      total_cnt++;
      if (ioctl_din !== 8'hFF) $display("FAIL ck_top din=%h expected=ff", ioctl_din);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_fetch();
      ram_gnt = 1'b1;
      ioctl_rd = 1'b1; ioctl_addr = 25'd2;
      tick(); ioctl_rd = 1'b0;
      tick();
      total_cnt++;
      if (ioctl_wait !== 1'b1 || ram_rd !== 1'b0)
         $display("FAIL rst_in_data wait=%b rd=%b expected wait=1 rd=0", ioctl_wait, ram_rd);
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({ioctl_din, ioctl_wait, ram_addr, ram_rd, busy, done} !== 22'd0)
         $display("FAIL rst_async din=%h wait=%b addr=%h rd=%b busy=%b done=%b expected all 0",
                  ioctl_din, ioctl_wait, ram_addr, ram_rd, busy, done);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL rst_no_done done=%b expected=0", done);
      else pass_cnt++;
      reset_n = 1'b1;
      tick();
      total_cnt++;
      if (busy !== 1'b1 || ioctl_din !== 8'h00 || done !== 1'b0)
         $display("FAIL rst_restart busy=%b din=%h done=%b expected busy=1 din=00 done=0",
                  busy, ioctl_din, done);
      else pass_cnt++;
      ioctl_rd = 1'b1; ioctl_addr = 25'd5;
      tick(); ioctl_rd = 1'b0; tick(); tick();
      total_cnt++;
      if (ioctl_din !== 8'h3C || ioctl_wait !== 1'b0)
         $display("FAIL rst_reread din=%h wait=%b expected din=3c wait=0", ioctl_din, ioctl_wait);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      test_reset();
      test_basic_read();
      test_gnt_stall();
      test_out_of_range();
      test_abort();
      test_unselected();
      test_checksum();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/nvram_upload_server.md
# nvram_upload_server

Serves MiSTer HPS upload (save) requests from the core's non-volatile RAM, which holds high scores and settings. It is the read-direction counterpart of the ioctl ROM download path. The block sits between hps_io's upload signals (`ioctl_upload`, `ioctl_rd`, `ioctl_din`, `ioctl_wait`) and one synchronous read port of the core's NVRAM. It arbitrates with the game through a grant input and stalls the HPS with `ioctl_wait` while each byte is fetched.

## Interface
- `ADDR_W`, 10: NVRAM address width; depth = 2^ADDR_W bytes.
- `INDEX`, 8'd4: `ioctl_index` value selecting this block.

- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_upload`  in  1  HPS upload session active (level).
- `ioctl_index`  in  8  session target index.
- `ioctl_rd`  in  1  one-cycle strobe: byte at `ioctl_addr` requested.
- `ioctl_addr`  in  25  requested byte address.
- `ioctl_din`  out  8  returned byte.
- `ioctl_wait`  out  1  HPS stall; byte not yet valid.
- `ram_addr`  out  ADDR_W  NVRAM read address.
- `ram_rd`  out  1  NVRAM read request; held until granted.
- `ram_gnt`  in  1  core grants the NVRAM port this cycle.
- `ram_q`  in  8  NVRAM data, valid the cycle after a granted `ram_rd`.
- `busy`  out  1  session active for this index; core pauses NVRAM writes.
- `done`  out  1  one-cycle pulse when a session ends.

## Operation
- Reset: every output is 0 and the state is IDLE. The checksum accumulator is 0.
- `sel` = `ioctl_upload && ioctl_index == INDEX`.
- The state machine has four states: IDLE, ARMED, REQ, DATA.
  - IDLE → ARMED when `sel`. On this transition the accumulator clears and `busy` goes to 1.
  - ARMED, on `ioctl_rd` with `ioctl_addr < 2^ADDR_W`: latch `ram_addr` = `ioctl_addr[ADDR_W-1:0]`, then go to REQ.
  - ARMED, on `ioctl_rd` with an out-of-range address: load `ioctl_din` = 8'hFF (or the checksum; see Configuration) and stay in ARMED.
  - REQ: `ram_rd` = 1. When `ram_gnt` = 1, go to DATA.
  - DATA: capture `ioctl_din` ← `ram_q`, add `ram_q` to the accumulator (mod 256), then go to ARMED.
- `ioctl_wait` is combinational: it equals `(state==REQ || state==DATA) || (state==ARMED && ioctl_rd && in_range)`. It is never high outside a selected session.
- If `ioctl_rd` arrives while in REQ or DATA, it is a protocol violation. It is ignored, and the address is not re-latched.
- If `sel` drops in any non-IDLE state, the session aborts:
  - next cycle: state goes to IDLE; `ram_rd`, `ioctl_wait` and `busy` go to 0;
  - `done` pulses for one cycle;
  - `ioctl_din` holds its last value.
- A change of `ioctl_index` during a session counts as `sel` dropping.
- `reset_n` asserted mid-fetch clears all state immediately. `done` does not pulse.
- `ioctl_addr` bits above ADDR_W only select the out-of-range path. Addresses never wrap.

## Timing
- Strobe cycle T with `ram_gnt` tied high:
  - T: `ioctl_wait` = 1.
  - T+1: `ram_rd` = 1.
  - T+2: DATA state.
  - T+3: `ioctl_din` valid, `ioctl_wait` = 0.
  - Latency is 3 cycles.
- Each cycle that `ram_gnt` stays low in REQ adds one cycle of latency.
- Out-of-range strobe at T: `ioctl_din` updates at T+1, and `ioctl_wait` is never raised.
- The earliest next accepted strobe is the cycle in which `ioctl_wait` is 0 and the state is ARMED.

## Configuration
- `NVRAM_UPLOAD_CKSUM_EN` defined: a read of address exactly 2^ADDR_W returns `(~acc + 1)`, the 8-bit two's complement of the sum of all bytes served in this session. All other out-of-range reads still return 8'hFF. The accumulator logic is present only with the macro.
- `NVRAM_UPLOAD_CKSUM_EN` undefined: every out-of-range read returns 8'hFF, and no accumulator is built.

## Test plan
- Preload RAM[5]=8'h3C, gnt=1, index 4. Strobe `ioctl_rd` at addr 5 → `ram_rd`/`ram_addr`=5 at T+1; `ioctl_din`=8'h3C with `ioctl_wait` low at T+3.
- Hold gnt=0 for 4 cycles after `ram_rd` rises → `ram_rd` held steady and `ioctl_wait` high throughout; data arrives at T+7.
- `ioctl_index`=8'd0 with strobes → `ioctl_wait`, `ram_rd` and `busy` stay 0; `ioctl_din` unchanged.
- Drop `ioctl_upload` in REQ → next cycle IDLE, `ram_rd`=0, `ioctl_wait`=0, `busy`=0, `done` high for exactly 1 cycle.
- ADDR_W=2, RAM={01,02,03,04}, sequential reads 0..4 with the macro defined → byte 4 = 8'hF6. Without the macro → 8'hFF; address 2^24 → 8'hFF in both builds.
- Pull `reset_n` low in DATA → all outputs 0 asynchronously; no `done` pulse; the next session starts cleanly.
